// File: rtl/top_level_cpu.sv
// top_level_cpu: five-stage pipelined 32-bit CPU (IF > ID > EX > MEM > WB) sharing one
// 2048x32 memory between instruction fetch and data access. The memory is preloaded through
// the loader port while cpu_en=0. No hazard detection and no forwarding: software pads with
// NOPs. Only ADD updates the Z/N/C flags and the result/carry outputs.
//
// Optional build macro: WRITE_THROUGH_RF_EN
//   defined   - an RF read in ID sees the value being written back in WB in the same cycle.
//   undefined - the RF read returns the value held before this cycle's write-back.

module top_level_cpu #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned NREG   = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cpu_en,
    input  logic [DATA_W-1:0] w_instruction,
    input  logic              w_enable,
    input  logic [ADDR_W-1:0] w_adrs,
    output logic              carry,
    output logic [DATA_W-1:0] result
);

    localparam int unsigned RegW     = $clog2(NREG);
    localparam int unsigned MemDepth = 2 ** ADDR_W;

    // Opcodes; 000..011 all decode as NOP.
    localparam logic [2:0] OpAdd    = 3'b100;
    localparam logic [2:0] OpBranch = 3'b101;
    localparam logic [2:0] OpStore  = 3'b110;
    localparam logic [2:0] OpLoad   = 3'b111;

    // Branch conditions; 101..111 never take.
    localparam logic [2:0] CondPos    = 3'b000;
    localparam logic [2:0] CondNeg    = 3'b001;
    localparam logic [2:0] CondCs     = 3'b010;
    localparam logic [2:0] CondAlways = 3'b011;
    localparam logic [2:0] CondEqz    = 3'b100;

    // Decoded instruction fields carried down the pipe; all-zero is a NOP.
    typedef struct packed {
        logic [2:0]        op;
        logic [2:0]        cond;
        logic [RegW-1:0]   rs;
        logic [RegW-1:0]   rd;
        logic [ADDR_W-1:0] adr;
    } instr_t;

    // Storage
    logic [DATA_W-1:0] mem [MemDepth];
    logic [DATA_W-1:0] rf  [NREG];

    // Pipeline state
    logic [ADDR_W-1:0] pc_q, pc_d;
    instr_t            if_id_q, if_id_d;
    instr_t            id_ex_q, id_ex_d;
    logic [DATA_W-1:0] id_ex_rs_val_q, id_ex_rd_val_q;
    instr_t            ex_mem_q;
    logic [DATA_W-1:0] ex_mem_rs_val_q, ex_mem_sum_q;
    logic              mem_wb_we_q, mem_wb_we_d;
    logic [RegW-1:0]   mem_wb_waddr_q, mem_wb_waddr_d;
    logic [DATA_W-1:0] mem_wb_data_q, mem_wb_data_d;

    // Flags and outputs
    logic              flag_z_q, flag_n_q, flag_c_q;
    logic [DATA_W-1:0] result_q;
    logic              carry_q;

    // Stage-local combinational signals
    logic [DATA_W-1:0] fetch_word;
    instr_t            fetch_instr;
    logic [DATA_W-1:0] id_rs_val, id_rd_val;
    logic [DATA_W:0]   ex_sum;
    logic              ex_is_add, ex_is_branch, ex_cond_ok, ex_taken;
    logic [ADDR_W-1:0] ex_target;
    logic [DATA_W-1:0] mem_load_word;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    logic unused_fetch_bits;
    logic unused_ex_mem_cond;

    assign result = result_q;
    assign carry  = carry_q;

    // IF: combinational fetch at PC and field extraction.
    always_comb begin
        fetch_word      = mem[pc_q];
        fetch_instr     = '0;
        fetch_instr.op  = fetch_word[31:29];
        fetch_instr.cond = fetch_word[26:24];
        fetch_instr.rs  = fetch_word[11 +: RegW];
        fetch_instr.rd  = fetch_word[0 +: RegW];
        fetch_instr.adr = fetch_word[0 +: ADDR_W];
    end

    assign unused_fetch_bits  = ^{fetch_word[28:27], fetch_word[23:16]};
    assign unused_ex_mem_cond = ^ex_mem_q.cond;

    // ID: register-file read of both operands (RS also supplies STORE data).
    always_comb begin
        id_rs_val = rf[if_id_q.rs];
        id_rd_val = rf[if_id_q.rd];
`ifdef WRITE_THROUGH_RF_EN
        if (mem_wb_we_q && (mem_wb_waddr_q == if_id_q.rs)) begin
            id_rs_val = mem_wb_data_q;
        end
        if (mem_wb_we_q && (mem_wb_waddr_q == if_id_q.rd)) begin
            id_rd_val = mem_wb_data_q;
        end
`endif
    end

    // EX: 33-bit add, branch condition evaluation against the registered flags.
    always_comb begin
        ex_sum       = {1'b0, id_ex_rd_val_q} + {1'b0, id_ex_rs_val_q};
        ex_is_add    = (id_ex_q.op == OpAdd);
        ex_is_branch = (id_ex_q.op == OpBranch);
        ex_target    = {{(ADDR_W - RegW){1'b0}}, id_ex_q.rs};
        ex_cond_ok   = 1'b0;
        case (id_ex_q.cond)
            CondPos:    ex_cond_ok = !flag_n_q && !flag_z_q;
            CondNeg:    ex_cond_ok = flag_n_q;
            CondCs:     ex_cond_ok = flag_c_q;
            CondAlways: ex_cond_ok = 1'b1;
            CondEqz:    ex_cond_ok = flag_z_q;
            default:    ex_cond_ok = 1'b0;
        endcase
        ex_taken = ex_is_branch && ex_cond_ok;
    end

    // Next PC and flush: a taken branch kills the instructions currently in IF and ID.
    always_comb begin
        pc_d    = pc_q + ADDR_W'(1);
        if_id_d = fetch_instr;
        id_ex_d = if_id_q;
        if (ex_taken) begin
            pc_d    = ex_target;
            if_id_d = '0;
            id_ex_d = '0;
        end
    end

    // MEM: data read for LOAD and selection of the write-back source.
    always_comb begin
        mem_load_word  = mem[ex_mem_q.adr];
        mem_wb_we_d    = (ex_mem_q.op == OpAdd) || (ex_mem_q.op == OpLoad);
        mem_wb_waddr_d = ex_mem_q.rd;
        mem_wb_data_d  = ex_mem_sum_q;
        if (ex_mem_q.op == OpLoad) begin
            mem_wb_waddr_d = ex_mem_q.rs;
            mem_wb_data_d  = mem_load_word;
        end
    end

    // Single memory write port: loader while halted, STORE in MEM while running.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = w_adrs;
        mem_wdata = w_instruction;
        if (cpu_en) begin
            mem_we    = (ex_mem_q.op == OpStore);
            mem_waddr = ex_mem_q.adr;
            mem_wdata = ex_mem_rs_val_q;
        end else begin
            mem_we = w_enable;
        end
    end

    // Pipeline registers, flags and outputs; all frozen while cpu_en=0.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc_q            <= '0;
            if_id_q         <= '0;
            id_ex_q         <= '0;
            id_ex_rs_val_q  <= '0;
            id_ex_rd_val_q  <= '0;
            ex_mem_q        <= '0;
            ex_mem_rs_val_q <= '0;
            ex_mem_sum_q    <= '0;
            mem_wb_we_q     <= 1'b0;
            mem_wb_waddr_q  <= '0;
            mem_wb_data_q   <= '0;
            flag_z_q        <= 1'b0;
            flag_n_q        <= 1'b0;
            flag_c_q        <= 1'b0;
            result_q        <= '0;
            carry_q         <= 1'b0;
        end else if (cpu_en) begin
            pc_q            <= pc_d;
            if_id_q         <= if_id_d;
            id_ex_q         <= id_ex_d;
            id_ex_rs_val_q  <= id_rs_val;
            id_ex_rd_val_q  <= id_rd_val;
            ex_mem_q        <= id_ex_q;
            ex_mem_rs_val_q <= id_ex_rs_val_q;
            ex_mem_sum_q    <= ex_sum[DATA_W-1:0];
            mem_wb_we_q     <= mem_wb_we_d;
            mem_wb_waddr_q  <= mem_wb_waddr_d;
            mem_wb_data_q   <= mem_wb_data_d;
            if (ex_is_add) begin
                flag_z_q <= (ex_sum[DATA_W-1:0] == '0);
                flag_n_q <= ex_sum[DATA_W-1];
                flag_c_q <= ex_sum[DATA_W];
                result_q <= ex_sum[DATA_W-1:0];
                carry_q  <= ex_sum[DATA_W];
            end
        end
    end

    // WB: register-file write, cleared on reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
        end else if (cpu_en && mem_wb_we_q) begin
            rf[mem_wb_waddr_q] <= mem_wb_data_q;
        end
    end

    // Unified memory write; contents survive reset. A same-cycle fetch sees the old word.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_top_level_cpu.sv
// Directed bench for top_level_cpu: preloads small programs through the loader port, runs them
// and compares result/carry (plus PC and selected memory words) at hand-computed cycles.

module tb_top_level_cpu;

    logic        clk;
    logic        resetn;
    logic        cpu_en;
    logic [31:0] w_instruction;
    logic        w_enable;
    logic [10:0] w_adrs;
    logic        carry;
    logic [31:0] result;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;

    top_level_cpu dut (
        .clk           (clk),
        .resetn        (resetn),
        .cpu_en        (cpu_en),
        .w_instruction (w_instruction),
        .w_enable      (w_enable),
        .w_adrs        (w_adrs),
        .carry         (carry),
        .result        (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    // Instruction builders.
    function automatic logic [31:0] i_add(input logic [4:0] rd, input logic [4:0] rs);
        return {3'b100, 13'b0, rs, 6'b0, rd};
    endfunction
    function automatic logic [31:0] i_br(input logic [2:0] cond, input logic [4:0] tgt);
        return {3'b101, 2'b0, cond, 8'b0, tgt, 11'b0};
    endfunction
    function automatic logic [31:0] i_st(input logic [4:0] rs, input logic [10:0] adr);
        return {3'b110, 13'b0, rs, adr};
    endfunction
    function automatic logic [31:0] i_ld(input logic [4:0] rs, input logic [10:0] adr);
        return {3'b111, 13'b0, rs, adr};
    endfunction

    // Loader write; called at a negedge, the write lands on the following posedge.
    task automatic load_word(input logic [10:0] adr, input logic [31:0] data);
        w_enable      = 1'b1;
        w_adrs        = adr;
        w_instruction = data;
        @(negedge clk);
        w_enable      = 1'b0;
    endtask

    task automatic load_common();
        for (int a = 0; a < 40; a++) load_word(11'(a), 32'h0);
        load_word(11'd0, 32'h0000_000e);
        load_word(11'd1, 32'h0000_000f);
        load_word(11'd2, 32'h0000_0000);
        load_word(11'h0ff, 32'hffff_ffff);
    endtask

    // Advance enabled clock edges until the run counter reaches n, then sample at negedge.
    task automatic run_to(input int n);
        while (cyc < n) begin
            @(posedge clk);
            cyc++;
        end
        @(negedge clk);
    endtask

    initial begin
        resetn        = 1'b0;
        cpu_en        = 1'b0;
        w_enable      = 1'b0;
        w_adrs        = '0;
        w_instruction = '0;
        repeat (2) @(negedge clk);
        check_eq("reset_result", result, 32'h0);
        check_eq("reset_carry", {31'b0, carry}, 32'h0);
        check_eq("reset_pc", {21'b0, dut.pc_q}, 32'h0);
        resetn = 1'b1;
        @(negedge clk);

        // Program 1: loads, two ADDs, untaken EQZ, taken POS back to 8, flushed STORE/ADD.
        load_common();
        load_word(11'd4,  i_ld(5'd0, 11'd0));
        load_word(11'd5,  i_ld(5'd1, 11'd1));
        load_word(11'd6,  i_ld(5'd2, 11'd2));
        load_word(11'd7,  i_ld(5'd15, 11'h0ff));
        load_word(11'd8,  i_add(5'd0, 5'd2));
        load_word(11'd13, i_add(5'd15, 5'd1));
        load_word(11'd17, i_br(3'b100, 5'd19));
        load_word(11'd18, i_br(3'b000, 5'd8));
        load_word(11'd19, i_st(5'd1, 11'd2));
        load_word(11'd20, i_add(5'd5, 5'd1));
        check_eq("halted_pc", {21'b0, dut.pc_q}, 32'h0);

        cpu_en = 1'b1;
        cyc    = 0;
        run_to(10);
        check_eq("p1_before_add8", result, 32'h0);
        run_to(11);
        check_eq("p1_add8_result", result, 32'h0000_000e);
        check_eq("p1_add8_carry", {31'b0, carry}, 32'h0);
        run_to(16);
        check_eq("p1_add13_result", result, 32'h0000_000e);
        check_eq("p1_add13_carry", {31'b0, carry}, 32'h1);
        run_to(23);
        check_eq("p1_flush_result", result, 32'h0000_000e);
        check_eq("p1_flush_carry", {31'b0, carry}, 32'h1);
        run_to(24);
        check_eq("p1_loop_add8_carry", {31'b0, carry}, 32'h0);
        check_eq("p1_mem2_untouched", dut.mem[2], 32'h0);
        run_to(25);
        check_eq("p1_pc_after_branch", {21'b0, dut.pc_q}, 32'd12);

        // Freeze for 20 cycles.
        cpu_en = 1'b0;
        repeat (20) @(negedge clk);
        check_eq("freeze_result", result, 32'h0000_000e);
        check_eq("freeze_carry", {31'b0, carry}, 32'h0);
        check_eq("freeze_pc", {21'b0, dut.pc_q}, 32'd12);

        // Resume; loader strobe while running must be ignored.
        cpu_en        = 1'b1;
        w_enable      = 1'b1;
        w_adrs        = 11'h0ff;
        w_instruction = 32'h0;
        run_to(28);
        w_enable = 1'b0;
        check_eq("resume_result", result, 32'h0000_000e);
        run_to(29);
        check_eq("p1_second_add13_result", result, 32'h0000_001d);
        check_eq("p1_second_add13_carry", {31'b0, carry}, 32'h0);
        run_to(42);
        check_eq("p1_third_add13_result", result, 32'h0000_002c);

        // Asynchronous reset mid-cycle.
        resetn = 1'b0;
        #1;
        check_eq("async_reset_result", result, 32'h0);
        check_eq("async_reset_carry", {31'b0, carry}, 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        cyc    = 0;
        run_to(11);
        check_eq("restart_add8_result", result, 32'h0000_000e);
        run_to(16);
        check_eq("restart_add13_carry", {31'b0, carry}, 32'h1);
        cpu_en = 1'b0;
        @(negedge clk);
        check_eq("wenable_ignored_mem", dut.mem[255], 32'hffff_ffff);

        // Program 2: zero ADD, taken EQZ to a STORE, reload and ADD of the stored value.
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        load_common();
        load_word(11'd4,  i_ld(5'd0, 11'd0));
        load_word(11'd5,  i_ld(5'd1, 11'd1));
        load_word(11'd6,  i_ld(5'd2, 11'd2));
        load_word(11'd7,  i_ld(5'd3, 11'd2));
        load_word(11'd11, i_add(5'd2, 5'd3));
        load_word(11'd12, i_br(3'b100, 5'd19));
        load_word(11'd13, i_add(5'd0, 5'd1));
        load_word(11'd14, i_add(5'd0, 5'd1));
        load_word(11'd19, i_st(5'd1, 11'd2));
        load_word(11'd21, i_ld(5'd2, 11'd2));
        load_word(11'd25, i_add(5'd4, 5'd2));
        load_word(11'd26, i_br(3'b011, 5'd26));

        cpu_en = 1'b1;
        cyc    = 0;
        run_to(18);
        check_eq("p2_mem2_before_store", dut.mem[2], 32'h0);
        check_eq("p2_flushed_adds", result, 32'h0);
        run_to(20);
        check_eq("p2_mem2_stored", dut.mem[2], 32'h0000_000f);
        run_to(23);
        check_eq("p2_before_final_add", result, 32'h0);
        run_to(24);
        check_eq("p2_reloaded_add_result", result, 32'h0000_000f);
        check_eq("p2_reloaded_add_carry", {31'b0, carry}, 32'h0);
        run_to(30);
        check_eq("p2_loop_stable", result, 32'h0000_000f);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
